// File: rtl/soc_ram_dma_if.sv
// soc_ram_dma_if: Avalon-MM word bus between the copy engine (master) and the SOC RAM (slave).
interface soc_ram_dma_if #(parameter int ADDR_W = 12);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              read;
    logic              write;
    logic [3:0]        byteenable;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              waitrequest;
    modport master(output address, chipselect, read, write, byteenable, writedata, input readdata, waitrequest);
    modport slave(input address, chipselect, read, write, byteenable, writedata, output readdata, waitrequest);
endinterface

// File: rtl/soc_ram_dma.sv
// soc_ram_dma: one-word-at-a-time RAM copy engine (read, fixed-latency wait, write) on Avalon-MM.
// Optional running checksum output csum_o enabled by SOC_RAM_DMA_CSUM_EN.
module soc_ram_dma #(
    parameter int ADDR_W       = 12,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    input  logic [ADDR_W:0]   length_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W:0]   words_done_o,
`ifdef SOC_RAM_DMA_CSUM_EN
    output logic [31:0]       csum_o,
`endif
    soc_ram_dma_if.master     avm
);
    typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, DONE} state_t;
    localparam logic [1:0]        LAT_INIT = 2'(READ_LATENCY - 1);
    localparam logic [ADDR_W-1:0] A_ONE    = 1;
    localparam logic [ADDR_W:0]   C_ONE    = 1;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
    logic [ADDR_W:0]   rem_q, rem_d, cnt_q, cnt_d;
    logic [31:0]       data_q, data_d;
    logic [1:0]        lat_q, lat_d;
`ifdef SOC_RAM_DMA_CSUM_EN
    logic [31:0]       csum_q, csum_d;
    assign csum_o = csum_q;
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            lat_q   <= '0;
`ifdef SOC_RAM_DMA_CSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            lat_q   <= lat_d;
`ifdef SOC_RAM_DMA_CSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        lat_d   = lat_q;
`ifdef SOC_RAM_DMA_CSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            IDLE: if (start_i) begin
                src_d   = src_addr_i;
                dst_d   = dst_addr_i;
                rem_d   = length_i;
                cnt_d   = '0;
`ifdef SOC_RAM_DMA_CSUM_EN
                csum_d  = '0;
`endif
                state_d = (length_i == '0) ? DONE : RD;
            end
            RD: if (!avm.waitrequest) begin
                lat_d   = LAT_INIT;
                state_d = RD_WAIT;
            end
            RD_WAIT: if (lat_q == '0) begin
                data_d  = avm.readdata;
`ifdef SOC_RAM_DMA_CSUM_EN
                csum_d  = csum_q + avm.readdata;
`endif
                state_d = WR;
            end else begin
                lat_d   = lat_q - 2'd1;
            end
            WR: if (!avm.waitrequest) begin
                src_d   = src_q + A_ONE;
                dst_d   = dst_q + A_ONE;
                cnt_d   = cnt_q + C_ONE;
                rem_d   = rem_q - C_ONE;
                state_d = (rem_q == C_ONE) ? DONE : RD;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // Bus outputs decode straight from state so they read as zero whenever idle.
    assign busy_o         = (state_q == RD) || (state_q == RD_WAIT) || (state_q == WR);
    assign done_o         = state_q == DONE;
    assign words_done_o   = cnt_q;
    assign avm.read       = state_q == RD;
    assign avm.write      = state_q == WR;
    assign avm.chipselect = (state_q == RD) || (state_q == WR);
    assign avm.address    = (state_q == RD) ? src_q : (state_q == WR) ? dst_q : '0;
    assign avm.writedata  = (state_q == WR) ? data_q : '0;
    assign avm.byteenable = 4'hf;
endmodule

// File: tb/tb_soc_ram_dma.sv
// tb_soc_ram_dma: directed checks of soc_ram_dma against a 1-cycle-latency RAM model.
module tb_soc_ram_dma;
    localparam int AW = 12;
    logic clk = 0, reset = 1, start_i = 0;
    logic [AW-1:0] src_i = 0, dst_i = 0;
    logic [AW:0] len_i = 0;
    logic busy_o, done_o;
    logic [AW:0] wd_o;
`ifdef SOC_RAM_DMA_CSUM_EN
    logic [31:0] csum_o;
`endif
    soc_ram_dma_if #(.ADDR_W(AW)) avm();
    soc_ram_dma #(.ADDR_W(AW), .READ_LATENCY(1)) dut (
        .clk(clk), .reset(reset), .start_i(start_i),
        .src_addr_i(src_i), .dst_addr_i(dst_i), .length_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .words_done_o(wd_o),
`ifdef SOC_RAM_DMA_CSUM_EN
        .csum_o(csum_o),
`endif
        .avm(avm)
    );
    always #5 clk = ~clk;
    logic [31:0] mem [0:4095];
    logic pre_we = 0;
    logic [AW-1:0] pre_a = 0;
    logic [31:0] pre_d = 0;
    int busy_cnt = 0, done_cnt = 0, rd_cnt = 0, wr_cnt = 0, total = 0, bad = 0;
    logic [AW-1:0] rd_log [$];
    logic [AW-1:0] wrap_a [4] = '{12'd4094, 12'd4095, 12'd0, 12'd1};
    logic [31:0] wrap_v [4] = '{32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003, 32'hA5A5_0004};
    // RAM slave plus edge-accurate activity counters
    always @(posedge clk) begin
        if (pre_we) mem[pre_a] <= pre_d;
        else if (avm.write && avm.chipselect && !avm.waitrequest) mem[avm.address] <= avm.writedata;
        if (avm.read && avm.chipselect && !avm.waitrequest) begin
            avm.readdata <= mem[avm.address];
            rd_cnt <= rd_cnt + 1;
            rd_log.push_back(avm.address);
        end
        if (avm.write && !avm.waitrequest) wr_cnt <= wr_cnt + 1;
        if (busy_o) busy_cnt <= busy_cnt + 1;
        if (done_o) done_cnt <= done_cnt + 1;
    end
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic poke(input logic [AW-1:0] a, input logic [31:0] d);
        pre_a = a; pre_d = d; pre_we = 1;
        @(negedge clk);
        pre_we = 0;
    endtask
    task automatic go(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW:0] n);
        src_i = s; dst_i = d; len_i = n; start_i = 1;
        @(negedge clk);
        start_i = 0;
    endtask
    task automatic wait_done(input int d0);
        for (int i = 0; i < 300 && done_cnt == d0; i++) @(negedge clk);
        chk("done_seen", 64'(done_cnt != d0), 1);
        repeat (2) @(negedge clk);
    endtask
    initial begin
        int b0, d0, r0, w0;
        avm.waitrequest = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_wd", wd_o, 0);
        chk("rst_rdwr", {avm.read, avm.write, avm.chipselect}, 0);
        chk("rst_addr", avm.address, 0);
        chk("rst_wdata", avm.writedata, 0);
        chk("rst_be", avm.byteenable, 4'hf);
        reset = 0;
        @(negedge clk);
        // basic copy
        for (int i = 0; i < 4; i++) poke(AW'(i), 32'(11 * (i + 1)));
        b0 = busy_cnt; d0 = done_cnt;
        go(0, 100, 4);
        wait_done(d0);
        chk("basic_busy", 64'(busy_cnt - b0), 12);
        chk("basic_done", 64'(done_cnt - d0), 1);
        chk("basic_wd", wd_o, 4);
        for (int i = 0; i < 4; i++) chk("basic_mem", mem[100 + i], 32'(11 * (i + 1)));
`ifdef SOC_RAM_DMA_CSUM_EN
        chk("basic_csum", csum_o, 110);
`endif
        // zero length
        b0 = busy_cnt; r0 = rd_cnt; w0 = wr_cnt;
        go(5, 6, 0);
        chk("zero_done", done_o, 1);
        chk("zero_busy", busy_o, 0);
        chk("zero_wd", wd_o, 0);
        @(negedge clk);
        chk("zero_done_end", done_o, 0);
        chk("zero_nobus", 64'((rd_cnt - r0) + (wr_cnt - w0) + (busy_cnt - b0)), 0);
        // address wrap-around
        for (int i = 0; i < 4; i++) poke(wrap_a[i], wrap_v[i]);
        r0 = rd_log.size(); d0 = done_cnt;
        go(4094, 10, 4);
        wait_done(d0);
        for (int i = 0; i < 4; i++) begin
            chk("wrap_raddr", rd_log[r0 + i], wrap_a[i]);
            chk("wrap_mem", mem[10 + i], wrap_v[i]);
        end
        // waitrequest stalls: 3 cycles in first RD, 2 in second WR
        poke(200, 32'h1234_5678);
        poke(201, 32'h9ABC_DEF0);
        b0 = busy_cnt; d0 = done_cnt;
        avm.waitrequest = 1;
        go(200, 300, 2);
        for (int i = 0; i < 4; i++) begin
            chk("stall_rd", {avm.read, avm.chipselect}, 2'b11);
            chk("stall_raddr", avm.address, 200);
            if (i < 3) @(negedge clk);
        end
        avm.waitrequest = 0;
        repeat (5) @(negedge clk);
        chk("stall_wr0", avm.write, 1);
        avm.waitrequest = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("stall_wr", {avm.write, avm.chipselect}, 2'b11);
            chk("stall_waddr", avm.address, 301);
            chk("stall_wdata", avm.writedata, 32'h9ABC_DEF0);
        end
        avm.waitrequest = 0;
        wait_done(d0);
        chk("stall_busy", 64'(busy_cnt - b0), 11);
        chk("stall_mem0", mem[300], 32'h1234_5678);
        chk("stall_mem1", mem[301], 32'h9ABC_DEF0);
        // reset during the third word's read wait
        for (int i = 0; i < 8; i++) poke(AW'(400 + i), 32'h4000 + 32'(i));
        for (int i = 0; i < 6; i++) poke(AW'(502 + i), 32'hDEAD_BEEF);
        d0 = done_cnt;
        go(400, 500, 8);
        repeat (7) @(negedge clk);
        chk("mid_busy_pre", {busy_o, avm.read, avm.write}, 3'b100);
        reset = 1;
        #1;
        chk("mid_busy", busy_o, 0);
        chk("mid_bus", {avm.read, avm.write, avm.chipselect}, 0);
        chk("mid_addr", avm.address, 0);
        chk("mid_wd", wd_o, 0);
        @(negedge clk);
        reset = 0;
        repeat (3) @(negedge clk);
        chk("mid_nodone", 64'(done_cnt - d0), 0);
        chk("mid_mem0", mem[500], 32'h4000);
        chk("mid_mem1", mem[501], 32'h4001);
        chk("mid_mem2", mem[502], 32'hDEAD_BEEF);
        d0 = done_cnt;
        go(400, 600, 2);
        wait_done(d0);
        chk("restart_wd", wd_o, 2);
        chk("restart_mem", {mem[600], mem[601]}, {32'h4000, 32'h4001});
        // start pulse while busy is ignored
        for (int i = 0; i < 3; i++) poke(AW'(700 + i), 32'h7000 + 32'(i));
        d0 = done_cnt;
        go(700, 800, 3);
        repeat (3) @(negedge clk);
        go(0, 900, 1);
        wait_done(d0);
        repeat (5) @(negedge clk);
        chk("ign_done", 64'(done_cnt - d0), 1);
        chk("ign_wd", wd_o, 3);
        chk("ign_busy", busy_o, 0);
        for (int i = 0; i < 3; i++) chk("ign_mem", mem[800 + i], 32'h7000 + 32'(i));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/soc_ram_dma.md
Name: soc_ram_dma

Overview:
- Avalon-MM master (initiator) word-copy engine that drives the on-chip SOC RAM slave port: reads N 32-bit words starting at a source word address, writes them starting at a destination word address.
- Sits beside the CPU in the SOC. Software or control logic loads src/dst/length and pulses start. The block reports busy, done and progress.
- Issues one transfer at a time: read, wait a fixed read latency, write. No pipelining, no bursts.

Parameters:
- ADDR_W, 12, word-address width; the address space is 2^ADDR_W words.
- READ_LATENCY, 1, fixed slave read latency in cycles. Legal range 1..4. The default of 1 matches a RAM with a registered address and unregistered q.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- src_addr  in  ADDR_W  first source word address
- dst_addr  in  ADDR_W  first destination word address
- length  in  ADDR_W+1  number of words, 0..2^ADDR_W
- busy  out  1  high in states RD, RD_WAIT, WR
- done  out  1  one-cycle pulse when a transfer completes
- words_done  out  ADDR_W+1  count of words written in the current or last transfer
- avm_address  out  ADDR_W  word address
- avm_chipselect  out  1  high whenever avm_read or avm_write is high
- avm_read  out  1  read request
- avm_write  out  1  write request
- avm_byteenable  out  4  always 4'b1111 while writing; 4'b1111 otherwise
- avm_writedata  out  32  data being written
- avm_readdata  in  32  slave read data
- avm_waitrequest  in  1  slave stall; tie to 0 for the SOC RAM

Behaviour:
- Reset values: every output is 0, except avm_byteenable = 4'b1111. Internal registers are cleared and the state is IDLE.
- Reset asserted mid-transfer aborts the transfer immediately. No done pulse is produced. Words already written stay in memory.
- The FSM has states IDLE, RD, RD_WAIT, WR, DONE.

FSM transitions:
- IDLE:
  - On start = 1, latch src, dst and length, and clear words_done.
  - If length = 0, go to DONE; otherwise go to RD.
  - A start pulse in any state other than IDLE is ignored.
- RD:
  - Drive avm_read = 1, avm_chipselect = 1, avm_address = current src.
  - Hold all three while avm_waitrequest = 1.
  - On the first edge with avm_waitrequest = 0, go to RD_WAIT and load the latency counter with READ_LATENCY-1.
- RD_WAIT:
  - Request lines are low.
  - Count down. On the edge where the counter is 0, capture avm_readdata into the data register and go to WR.
- WR:
  - Drive avm_write = 1, avm_chipselect = 1, avm_address = current dst, avm_writedata = the captured data.
  - Hold while avm_waitrequest = 1.
  - On acceptance: increment src, dst and words_done, and decrement the remaining count.
  - If remaining becomes 0, go to DONE; otherwise go to RD.
- DONE:
  - done = 1 for exactly one cycle, then go to IDLE.

Arithmetic and boundary rules:
- src and dst increment modulo 2^ADDR_W, so 4095 + 1 wraps to 0.
- A length of 2^ADDR_W (4096) is legal and copies the whole address space.
- Overlapping regions are copied in ascending order with no hazard protection. When dst > src and the regions overlap, the source is overwritten: this is the documented behaviour.

Timing:
- With waitrequest = 0, each word takes 2 + READ_LATENCY cycles.
- busy rises the cycle after start is sampled.
- done pulses the cycle after the last write is accepted.
- words_done holds its final value until the next accepted start.

Optional Feature:
- Macro: SOC_RAM_DMA_CSUM_EN.
- When defined:
  - Adds an output port csum (32 bits): a running modulo-2^32 sum of every word captured in RD_WAIT.
  - csum is cleared on an accepted start and on reset.
  - csum is stable and valid when done pulses.
- When undefined:
  - The port is absent and no adder is synthesised.

Test Plan:
- Basic copy: preload RAM[0..3] = 11,22,33,44. Pulse start with src=0, dst=100, len=4, waitrequest=0.
  - Expect RAM[100..103] = 11,22,33,44, busy high for 12 cycles, one done pulse, words_done = 4, csum = 110 if enabled.
- Zero length: start with len=0.
  - Expect done the cycle after start, busy never high, no avm_read/avm_write, words_done = 0.
- Wrap-around: src=4094, dst=10, len=4, with RAM[4094]=A, [4095]=B, [0]=C, [1]=D.
  - Expect RAM[10..13] = A,B,C,D and read addresses 4094, 4095, 0, 1.
- Waitrequest stall: len=2, waitrequest held high for 3 cycles during the first RD and 2 cycles during the second WR.
  - Expect address and request held stable while stalled, correct data, busy for 6+5 = 11 cycles.
- Reset mid-operation: len=8, assert reset during the 3rd word's RD_WAIT.
  - Expect all outputs to return to 0 immediately, no done pulse, RAM[dst..dst+1] written and dst+2 onward untouched.
  - A subsequent start then completes normally.
- Start while busy: second start pulse in the middle of a len=3 transfer.
  - Expect it to be ignored, exactly one done pulse, words_done = 3.
